// File: rtl/ring_pattern_monitor.sv
// Checker for a two-hot 8-bit ring counter rotating left by 2: locks, decodes phase, counts errors.
// Optional macro RING_MON_CLR_EN adds a clr_err input that clears error/revolution counters.
module ring_pattern_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RING_MON_CLR_EN
  input  logic             clr_err,
`endif
  input  logic             en,
  input  logic [7:0]       pattern_in,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [REV_W-1:0] rev_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

  localparam logic [3:0] LockCntL = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic       clr;
  logic       legal;
  logic       match;
  logic       err_event;
  logic [1:0] dec_phase;
  logic [7:0] expected;
  logic [3:0] match_cnt_inc;

`ifdef RING_MON_CLR_EN
  assign clr = clr_err;
`else
  assign clr = 1'b0;
`endif

  assign expected      = {prev_q[5:0], prev_q[7:6]};
  assign match         = (pattern_in == expected);
  assign match_cnt_inc = match_cnt_q + 4'd1;

  always_comb begin
    legal     = 1'b1;
    dec_phase = 2'd0;
    unique case (pattern_in)
      8'h03:   dec_phase = 2'd0;
      8'h0C:   dec_phase = 2'd1;
      8'h30:   dec_phase = 2'd2;
      8'hC0:   dec_phase = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    phase_d     = phase_q;
    rev_d       = rev_q;
    err_event   = 1'b0;

    if (en) begin
      case (state_q)
        StHunt: begin
          if (legal) begin
            prev_d      = pattern_in;
            phase_d     = dec_phase;
            match_cnt_d = 4'd0;
            state_d     = StCheck;
          end
        end
        StCheck: begin
          if (match) begin
            prev_d      = pattern_in;
            phase_d     = dec_phase;
            match_cnt_d = match_cnt_inc;
            if (match_cnt_inc == LockCntL) state_d = StLocked;
          end else if (legal) begin
            prev_d      = pattern_in;
            phase_d     = dec_phase;
            match_cnt_d = 4'd0;
          end else begin
            state_d     = StHunt;
            phase_d     = 2'd0;
            match_cnt_d = 4'd0;
          end
        end
        StLocked: begin
          if (match) begin
            prev_d  = pattern_in;
            phase_d = dec_phase;
            if (prev_q == 8'hC0) rev_d = rev_q + REV_W'(1);
          end else begin
            // The offending sample is discarded; hunting resumes on the next strobe.
            err_event   = 1'b1;
            state_d     = StHunt;
            phase_d     = 2'd0;
            match_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d     = StHunt;
          phase_d     = 2'd0;
          match_cnt_d = 4'd0;
        end
      endcase
    end

    err_pulse_d  = err_event;
    err_sticky_d = err_sticky_q | err_event;
    err_cnt_d    = err_cnt_q;
    if (err_event && (err_cnt_q != ErrMax)) err_cnt_d = err_cnt_q + ERR_W'(1);

    // A clear coinciding with an error leaves exactly that one error recorded.
    if (clr) begin
      rev_d        = '0;
      err_sticky_d = err_event;
      err_cnt_d    = err_event ? ERR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHunt;
      prev_q       <= 8'h00;
      match_cnt_q  <= 4'd0;
      phase_q      <= 2'd0;
      rev_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_cnt_q  <= match_cnt_d;
      phase_q      <= phase_d;
      rev_q        <= rev_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = (state_q == StLocked);
  assign phase      = phase_q;
  assign rev_count  = rev_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ring_pattern_monitor.sv
// Directed scoreboard bench for ring_pattern_monitor (LOCK_CNT=3, ERR_W=2).
// Clear-input steps are included only when RING_MON_CLR_EN is defined.
module tb_ring_pattern_monitor;

  logic       clk;
  logic       rst;
  logic       clr_err;
  logic       en;
  logic [7:0] pattern_in;
  logic       locked;
  logic [1:0] phase;
  logic [7:0] rev_count;
  logic       err_pulse;
  logic       err_sticky;
  logic [1:0] err_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       l;
    logic [1:0] ph;
    logic [7:0] rv;
    logic       pu;
    logic       st;
    logic [1:0] ec;
  } exp_t;

  exp_t sb[$];

  ring_pattern_monitor #(
    .LOCK_CNT(3),
    .REV_W   (8),
    .ERR_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RING_MON_CLR_EN
    .clr_err   (clr_err),
`endif
    .en        (en),
    .pattern_in(pattern_in),
    .locked    (locked),
    .phase     (phase),
    .rev_count (rev_count),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, then compare after the edge.
  task automatic step(input logic e, input logic [7:0] p, input logic c,
                      input logic l, input logic [1:0] ph, input logic [7:0] rv,
                      input logic pu, input logic st, input logic [1:0] ec);
    exp_t x;
    en         = e;
    pattern_in = p;
    clr_err    = c;
    sb.push_back('{l: l, ph: ph, rv: rv, pu: pu, st: st, ec: ec});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("locked", 32'(locked), 32'(x.l));
    chk("phase", 32'(phase), 32'(x.ph));
    chk("rev_count", 32'(rev_count), 32'(x.rv));
    chk("err_pulse", 32'(err_pulse), 32'(x.pu));
    chk("err_sticky", 32'(err_sticky), 32'(x.st));
    chk("err_count", 32'(err_count), 32'(x.ec));
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    clr_err    = 1'b0;
    pattern_in = 8'h00;

    // Reset with en high and an illegal pattern
    step(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Lock after three good transitions, then one revolution
    step(1, 8'h03, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8'h0C, 0, 0, 1, 0, 0, 0, 0);
    step(1, 8'h30, 0, 0, 2, 0, 0, 0, 0);
    step(1, 8'hC0, 0, 1, 3, 0, 0, 0, 0);
    step(1, 8'h03, 0, 1, 0, 1, 0, 0, 0);
    step(1, 8'h0C, 0, 1, 1, 1, 0, 0, 0);

    // Continue, then a locked mismatch (30 where 0C is due)
    step(1, 8'h30, 0, 1, 2, 1, 0, 0, 0);
    step(1, 8'hC0, 0, 1, 3, 1, 0, 0, 0);
    step(1, 8'h03, 0, 1, 0, 2, 0, 0, 0);
    step(1, 8'h30, 0, 0, 0, 2, 1, 1, 1);
    step(1, 8'h03, 0, 0, 0, 2, 0, 1, 1);
    step(1, 8'h0C, 0, 0, 1, 2, 0, 1, 1);
    step(1, 8'h30, 0, 0, 2, 2, 0, 1, 1);
    step(1, 8'hC0, 0, 1, 3, 2, 0, 1, 1);

    // en gating while locked: illegal value ignored
    step(0, 8'h55, 0, 1, 3, 2, 0, 1, 1);
    step(0, 8'h55, 0, 1, 3, 2, 0, 1, 1);
    step(0, 8'h55, 0, 1, 3, 2, 0, 1, 1);
    step(1, 8'h03, 0, 1, 0, 3, 0, 1, 1);

    // Synchronous reset mid-lock, then hunt robustness
    rst = 1'b1;
    step(1, 8'h03, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 8'h05, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8'h0C, 0, 0, 1, 0, 0, 0, 0);
    step(1, 8'h30, 0, 0, 2, 0, 0, 0, 0);
    step(1, 8'h0C, 0, 0, 1, 0, 0, 0, 0);
    // Count restarted at 0C: three more good samples are needed; C0->03 in CHECK is no revolution
    step(1, 8'h30, 0, 0, 2, 0, 0, 0, 0);
    step(1, 8'hC0, 0, 0, 3, 0, 0, 0, 0);
    step(1, 8'h03, 0, 1, 0, 0, 0, 0, 0);

    // Five locked errors saturate a 2-bit counter at 3
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] ec;
      ec = (k > 3) ? 2'd3 : 2'(k);
      step(1, 8'h55, 0, 0, 0, 0, 1, 1, ec);
      if (k < 5) begin
        step(1, 8'h03, 0, 0, 0, 0, 0, 1, ec);
        step(1, 8'h0C, 0, 0, 1, 0, 0, 1, ec);
        step(1, 8'h30, 0, 0, 2, 0, 0, 1, ec);
        step(1, 8'hC0, 0, 1, 3, 0, 0, 1, ec);
      end
    end
    step(0, 8'h55, 0, 0, 0, 0, 0, 1, 3);

`ifdef RING_MON_CLR_EN
    step(1, 8'h03, 0, 0, 0, 0, 0, 1, 3);
    step(1, 8'h0C, 0, 0, 1, 0, 0, 1, 3);
    step(1, 8'h30, 0, 0, 2, 0, 0, 1, 3);
    step(1, 8'hC0, 0, 1, 3, 0, 0, 1, 3);
    step(1, 8'h03, 0, 1, 0, 1, 0, 1, 3);
    // Clear with en low
    step(0, 8'h55, 1, 1, 0, 0, 0, 0, 0);
    // Clear coinciding with a locked error: the error wins
    step(1, 8'h55, 1, 0, 0, 0, 1, 1, 1);
    step(0, 8'h55, 0, 0, 0, 0, 0, 1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
